// File: rtl/wb_bus_pkg.sv
// rtl/wb_bus_pkg.sv - shared types and constants for the Wishbone shared-bus mux
// Provides the bus ownership state enum, master index type, master count
// and watchdog counter width used by wb_shared_bus_mux and wb_bus_watchdog.
package wb_bus_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int WDW         = 16;

  typedef logic [1:0] mst_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } bus_state_t;

endpackage

// File: rtl/wb_bus_watchdog.sv
// rtl/wb_bus_watchdog.sv - stall counter that flags a cycle stuck without termination
// Ports:
//   CLK, RST  clock, asynchronous active-high reset
//   inc       count one stalled strobe cycle
//   clr       restart the count (takes priority over inc)
//   tmo_hit   count has reached TMO
module wb_bus_watchdog
  import wb_bus_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic tmo_hit
);

  logic [WDW-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tmo_hit = (count == WDW'(TMO));

endmodule

// File: rtl/wb_shared_bus_mux.sv
// rtl/wb_shared_bus_mux.sv - locks a granted master onto the shared Wishbone slave port
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   GNT, COMCYC           registered grant index and arbitration-complete flag
//   M_CYC..M_SEL          per-master request fields, master n in slice n
//   M_ACK, M_ERR, M_RTY   per-master terminations, only the owner's bit can be set
//   M_DATI                slave read data broadcast to all masters
//   S_CYC..S_SEL          shared slave request fields
//   S_DATI, S_ACK..S_RTY  slave read data and terminations
//   OWNER, BUSY           locked owner index and ownership flag
//   TMO_EV                one-cycle pulse when the watchdog terminates a cycle
module wb_shared_bus_mux
  import wb_bus_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [1:0]                    GNT,
  input  logic                          COMCYC,
  input  logic [NUM_MASTERS-1:0]        M_CYC,
  input  logic [NUM_MASTERS-1:0]        M_STB,
  input  logic [NUM_MASTERS-1:0]        M_WE,
  input  logic [NUM_MASTERS*AW-1:0]     M_ADR,
  input  logic [NUM_MASTERS*DW-1:0]     M_DATO,
  input  logic [NUM_MASTERS*DW/8-1:0]   M_SEL,
  output logic [NUM_MASTERS-1:0]        M_ACK,
  output logic [NUM_MASTERS-1:0]        M_ERR,
  output logic [NUM_MASTERS-1:0]        M_RTY,
  output logic [DW-1:0]                 M_DATI,
  output logic                          S_CYC,
  output logic                          S_STB,
  output logic                          S_WE,
  output logic [AW-1:0]                 S_ADR,
  output logic [DW-1:0]                 S_DATO,
  output logic [DW/8-1:0]               S_SEL,
  input  logic [DW-1:0]                 S_DATI,
  input  logic                          S_ACK,
  input  logic                          S_ERR,
  input  logic                          S_RTY,
  output logic [1:0]                    OWNER,
  output logic                          BUSY,
  output logic                          TMO_EV
);

  localparam int SW = DW / 8;

  bus_state_t state;
  bus_state_t next_state;
  mst_idx_t   owner;

  logic own;
  logic own_cyc;
  logic slv_term;
  logic tmo_hit;
  logic tmo_fire;
  logic wd_inc;
  logic wd_clr;

  assign own      = (state == OWN);
  assign own_cyc  = own & M_CYC[owner];
  assign slv_term = S_ACK | S_ERR | S_RTY;
  // A slave termination landing on the expiry cycle completes the transfer
  // normally, so the watchdog only fires when the slave stays silent.
  assign tmo_fire = own_cyc & tmo_hit & ~slv_term;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Owner latch; only written on the IDLE->OWN transition so arbiter grant
  // changes are ignored for the rest of the bus cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner <= '0;
    end else if (state == IDLE && next_state == OWN) begin
      owner <= GNT;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (COMCYC && M_CYC[GNT]) next_state = OWN;
      OWN:     if (!M_CYC[owner])        next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: routing and terminations
  always_comb begin
    S_CYC  = 1'b0;
    S_STB  = 1'b0;
    S_WE   = 1'b0;
    S_ADR  = '0;
    S_DATO = '0;
    S_SEL  = '0;
    M_ACK  = '0;
    M_ERR  = '0;
    M_RTY  = '0;
    if (own) begin
      S_CYC  = own_cyc;
      S_STB  = M_STB[owner] & ~tmo_hit;
      S_WE   = M_WE[owner];
      S_ADR  = M_ADR[int'(owner)*AW +: AW];
      S_DATO = M_DATO[int'(owner)*DW +: DW];
      S_SEL  = M_SEL[int'(owner)*SW +: SW];
      // ERR outranks RTY outranks ACK so the master sees exactly one.
      M_ERR[owner] = (own_cyc & S_ERR) | tmo_fire;
      M_RTY[owner] = own_cyc & S_RTY & ~S_ERR;
      M_ACK[owner] = own_cyc & S_ACK & ~S_ERR & ~S_RTY;
    end
  end

  assign M_DATI = S_DATI;
  assign OWNER  = owner;
  assign BUSY   = own;
  assign TMO_EV = tmo_fire;

  assign wd_inc = S_STB & ~slv_term;
  assign wd_clr = ~own_cyc | slv_term | tmo_hit;

  wb_bus_watchdog #(
    .TMO (TMO)
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .inc     (wd_inc),
    .clr     (wd_clr),
    .tmo_hit (tmo_hit)
  );

endmodule
